// File: rtl/mem_access.sv
// Memory-access stage: data RAM with byte-lane stores/loads and a two-cycle registered write-back.
// Optional lane/alignment checking and the MEM_misalign port are enabled by defining MEM_MISALIGN_CHK_EN.
module mem_access #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  EX_rd,
    input  logic [31:0] EX_x_rd,
    input  logic        EX_x_rd_vld,
    input  logic [31:0] EX_MEM_addr,
    input  logic [3:0]  EX_MEM_rden,
    input  logic        EX_MEM_rden_SEXT,
    input  logic [3:0]  EX_MEM_wren,
    input  logic [31:0] EX_MEM_wrdata,
    output logic [4:0]  MEM_rd,
    output logic [31:0] MEM_x_rd,
    output logic        MEM_x_rd_vld
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic        MEM_misalign
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           rdata_q;
    logic [ADDR_WIDTH-1:0] widx_c;
    logic                  is_store_c;
    logic                  is_load_c;
    logic                  mis_c;
    logic                  store_en_c;

    logic [4:0]  s1_rd;
    logic [31:0] s1_x_rd;
    logic        s1_vld;
    logic [3:0]  s1_rden;
    logic        s1_sext;
    logic        s1_mis;
    logic [31:0] load_val_c;

    // Address bits outside the word index only alias; sink them explicitly.
    logic unused_addr;
    assign unused_addr = ^{EX_MEM_addr[31:ADDR_WIDTH+2], EX_MEM_addr[1:0]};

    assign widx_c     = EX_MEM_addr[ADDR_WIDTH+1:2];
    assign is_store_c = |EX_MEM_wren;
    assign is_load_c  = (|EX_MEM_rden) && !is_store_c;

`ifdef MEM_MISALIGN_CHK_EN
    function automatic logic lanes_ok(input logic [3:0] lanes, input logic [1:0] a);
        case (lanes)
            4'b1111, 4'b0011, 4'b0001: return a == 2'd0;
            4'b0010:                   return a == 2'd1;
            4'b1100, 4'b0100:          return a == 2'd2;
            4'b1000:                   return a == 2'd3;
            default:                   return 1'b0;
        endcase
    endfunction

    logic [3:0] access_lanes_c;
    // A simultaneous store wins, so its lanes are the ones that get checked.
    assign access_lanes_c = is_store_c ? EX_MEM_wren : EX_MEM_rden;
    assign mis_c = (|access_lanes_c) && !lanes_ok(access_lanes_c, EX_MEM_addr[1:0]);
`else
    assign mis_c = 1'b0;
`endif

    assign store_en_c = is_store_c && !mis_c;

    // RAM array and read port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (store_en_c) begin
            for (int i = 0; i < 4; i++) begin
                if (EX_MEM_wren[i]) begin
                    mem[widx_c][8*i +: 8] <= EX_MEM_wrdata[8*i +: 8];
                end
            end
        end
        if (is_load_c) begin
            rdata_q <= mem[widx_c];
        end
    end

    // Stage 1 pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rd   <= 5'd0;
            s1_x_rd <= 32'd0;
            s1_vld  <= 1'b0;
            s1_rden <= 4'd0;
            s1_sext <= 1'b0;
            s1_mis  <= 1'b0;
        end else begin
            s1_rd   <= EX_rd;
            s1_x_rd <= EX_x_rd;
            s1_vld  <= EX_x_rd_vld && (EX_rd != 5'd0) && !is_store_c && !mis_c;
            s1_rden <= is_load_c ? EX_MEM_rden : 4'd0;
            s1_sext <= EX_MEM_rden_SEXT;
            s1_mis  <= mis_c;
        end
    end

    // Lane extraction with zero/sign extension.
    always_comb begin
        load_val_c = 32'd0;
        case (s1_rden)
            4'b0001: load_val_c = {{24{s1_sext & rdata_q[7]}},  rdata_q[7:0]};
            4'b0010: load_val_c = {{24{s1_sext & rdata_q[15]}}, rdata_q[15:8]};
            4'b0100: load_val_c = {{24{s1_sext & rdata_q[23]}}, rdata_q[23:16]};
            4'b1000: load_val_c = {{24{s1_sext & rdata_q[31]}}, rdata_q[31:24]};
            4'b0011: load_val_c = {{16{s1_sext & rdata_q[15]}}, rdata_q[15:0]};
            4'b1100: load_val_c = {{16{s1_sext & rdata_q[31]}}, rdata_q[31:16]};
            4'b1111: load_val_c = rdata_q;
            default: load_val_c = 32'd0;
        endcase
    end

    // Stage 2 registered write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MEM_rd       <= 5'd0;
            MEM_x_rd     <= 32'd0;
            MEM_x_rd_vld <= 1'b0;
        end else begin
            MEM_rd       <= s1_rd;
            MEM_x_rd     <= (|s1_rden) ? load_val_c : s1_x_rd;
            MEM_x_rd_vld <= s1_vld;
        end
    end

`ifdef MEM_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MEM_misalign <= 1'b0;
        end else begin
            MEM_misalign <= s1_mis;
        end
    end
`else
    logic unused_mis;
    assign unused_mis = s1_mis;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (default build; misalign tests when MEM_MISALIGN_CHK_EN is defined).
module tb_mem_access;

    logic        clk;
    logic        rst_n;
    logic [4:0]  EX_rd;
    logic [31:0] EX_x_rd;
    logic        EX_x_rd_vld;
    logic [31:0] EX_MEM_addr;
    logic [3:0]  EX_MEM_rden;
    logic        EX_MEM_rden_SEXT;
    logic [3:0]  EX_MEM_wren;
    logic [31:0] EX_MEM_wrdata;
    logic [4:0]  MEM_rd;
    logic [31:0] MEM_x_rd;
    logic        MEM_x_rd_vld;
`ifdef MEM_MISALIGN_CHK_EN
    logic        MEM_misalign;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mem_access dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .EX_rd            (EX_rd),
        .EX_x_rd          (EX_x_rd),
        .EX_x_rd_vld      (EX_x_rd_vld),
        .EX_MEM_addr      (EX_MEM_addr),
        .EX_MEM_rden      (EX_MEM_rden),
        .EX_MEM_rden_SEXT (EX_MEM_rden_SEXT),
        .EX_MEM_wren      (EX_MEM_wren),
        .EX_MEM_wrdata    (EX_MEM_wrdata),
        .MEM_rd           (MEM_rd),
        .MEM_x_rd         (MEM_x_rd),
        .MEM_x_rd_vld     (MEM_x_rd_vld)
`ifdef MEM_MISALIGN_CHK_EN
        ,
        .MEM_misalign     (MEM_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [31:0] x, input logic vld,
                         input logic [31:0] addr, input logic [3:0] rden, input logic sext,
                         input logic [3:0] wren, input logic [31:0] wdata);
        EX_rd            = rd;
        EX_x_rd          = x;
        EX_x_rd_vld      = vld;
        EX_MEM_addr      = addr;
        EX_MEM_rden      = rden;
        EX_MEM_rden_SEXT = sext;
        EX_MEM_wren      = wren;
        EX_MEM_wrdata    = wdata;
    endtask

    task automatic send(input logic [4:0] rd, input logic [31:0] x, input logic vld,
                        input logic [31:0] addr, input logic [3:0] rden, input logic sext,
                        input logic [3:0] wren, input logic [31:0] wdata);
        drive(rd, x, vld, addr, rden, sext, wren, wdata);
        step();
    endtask

    task automatic flush();
        drive(5'd0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0);
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(5'd0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0);
        step();
        step();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rd=%0d x=%h vld=%b, want 0/0/0", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
`ifdef MEM_MISALIGN_CHK_EN
        n_cmp++;
        if (MEM_misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_misalign: got %b want 0", MEM_misalign);
        end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_loads();
        send(5'd0, 32'd0, 1'b0, 32'h100, 4'b0000, 1'b0, 4'b1111, 32'hDEADBEEF);
        send(5'd3, 32'd0, 1'b1, 32'h101, 4'b0010, 1'b1, 4'b0000, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd3, 32'hFFFFFFBE, 1'b1}) begin
            n_bad++;
            $display("FAIL lb_sext: got rd=%0d x=%h vld=%b, want 3/ffffffbe/1", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
        send(5'd4, 32'd0, 1'b1, 32'h103, 4'b1000, 1'b0, 4'b0000, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd4, 32'h000000DE, 1'b1}) begin
            n_bad++;
            $display("FAIL lbu: got rd=%0d x=%h vld=%b, want 4/000000de/1", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
        send(5'd5, 32'd0, 1'b1, 32'h102, 4'b1100, 1'b1, 4'b0000, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd5, 32'hFFFFDEAD, 1'b1}) begin
            n_bad++;
            $display("FAIL lh_sext: got rd=%0d x=%h vld=%b, want 5/ffffdead/1", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
        send(5'd6, 32'd0, 1'b1, 32'h100, 4'b0011, 1'b0, 4'b0000, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd6, 32'h0000BEEF, 1'b1}) begin
            n_bad++;
            $display("FAIL lhu: got rd=%0d x=%h vld=%b, want 6/0000beef/1", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
    endtask

    task automatic test_back_to_back();
        send(5'd0, 32'd0, 1'b0, 32'h102, 4'b0000, 1'b0, 4'b0100, 32'h55555555);
        send(5'd7, 32'd0, 1'b1, 32'h100, 4'b1111, 1'b0, 4'b0000, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd7, 32'hDE55BEEF, 1'b1}) begin
            n_bad++;
            $display("FAIL sb_then_lw: got rd=%0d x=%h vld=%b, want 7/de55beef/1", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
        send(5'd1, 32'hAAAA0001, 1'b1, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0);
        send(5'd2, 32'hBBBB0002, 1'b1, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0);
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd1, 32'hAAAA0001, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_first: got rd=%0d x=%h vld=%b, want 1/aaaa0001/1", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd2, 32'hBBBB0002, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_second: got rd=%0d x=%h vld=%b, want 2/bbbb0002/1", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
    endtask

    task automatic test_pass_through();
        send(5'd5, 32'h12345678, 1'b1, 32'h300, 4'd0, 1'b0, 4'd0, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd5, 32'h12345678, 1'b1}) begin
            n_bad++;
            $display("FAIL alu_pass: got rd=%0d x=%h vld=%b, want 5/12345678/1", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
        send(5'd0, 32'h12345678, 1'b1, 32'h300, 4'd0, 1'b0, 4'd0, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd0, 32'h12345678, 1'b0}) begin
            n_bad++;
            $display("FAIL alu_rd0: got rd=%0d x=%h vld=%b, want 0/12345678/0", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
    endtask

    task automatic test_store_no_wb();
        send(5'd4, 32'h00000777, 1'b1, 32'h200, 4'b0000, 1'b0, 4'b1111, 32'h11223344);
        flush();
        n_cmp++;
        if (MEM_x_rd_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL store_no_wb: got vld=%b want 0", MEM_x_rd_vld);
        end
        send(5'd9, 32'h00000999, 1'b1, 32'h200, 4'b1111, 1'b0, 4'b0001, 32'hAAAAAAAA);
        flush();
        n_cmp++;
        if (MEM_x_rd_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL ld_st_collide_vld: got vld=%b want 0", MEM_x_rd_vld);
        end
        send(5'd10, 32'd0, 1'b1, 32'h200, 4'b1111, 1'b0, 4'b0000, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd10, 32'h112233AA, 1'b1}) begin
            n_bad++;
            $display("FAIL ld_st_collide_data: got rd=%0d x=%h vld=%b, want 10/112233aa/1", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
    endtask

    task automatic test_illegal_pattern();
        logic exp_vld;
`ifdef MEM_MISALIGN_CHK_EN
        exp_vld = 1'b0;
`else
        exp_vld = 1'b1;
`endif
        send(5'd11, 32'h0000FFFF, 1'b1, 32'h100, 4'b0101, 1'b1, 4'b0000, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd11, 32'h00000000, exp_vld}) begin
            n_bad++;
            $display("FAIL illegal_rden: got rd=%0d x=%h vld=%b, want 11/00000000/%b", MEM_rd, MEM_x_rd, MEM_x_rd_vld, exp_vld);
        end
    endtask

    task automatic test_wrap();
        send(5'd0, 32'd0, 1'b0, 32'h4100, 4'b0000, 1'b0, 4'b1111, 32'hCAFEF00D);
        send(5'd12, 32'd0, 1'b1, 32'h100, 4'b1111, 1'b0, 4'b0000, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd12, 32'hCAFEF00D, 1'b1}) begin
            n_bad++;
            $display("FAIL addr_wrap: got rd=%0d x=%h vld=%b, want 12/cafef00d/1", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
    endtask

    task automatic test_mid_reset();
        send(5'd6, 32'd0, 1'b1, 32'h200, 4'b1111, 1'b0, 4'b0000, 32'd0);
        drive(5'd5, 32'h00000055, 1'b1, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== 38'd0) begin
            n_bad++;
            $display("FAIL mid_reset_async: got rd=%0d x=%h vld=%b, want 0/0/0", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
        step();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== 38'd0) begin
            n_bad++;
            $display("FAIL mid_reset_held: got rd=%0d x=%h vld=%b, want 0/0/0", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
        rst_n = 1'b1;
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== 38'd0) begin
            n_bad++;
            $display("FAIL mid_reset_after: got rd=%0d x=%h vld=%b, want 0/0/0", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
        send(5'd13, 32'd0, 1'b1, 32'h200, 4'b1111, 1'b0, 4'b0000, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd13, 32'h112233AA, 1'b1}) begin
            n_bad++;
            $display("FAIL ram_survives_reset: got rd=%0d x=%h vld=%b, want 13/112233aa/1", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
    endtask

`ifdef MEM_MISALIGN_CHK_EN
    task automatic test_misalign();
        send(5'd8, 32'd0, 1'b1, 32'h102, 4'b1111, 1'b0, 4'b0000, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_misalign, MEM_x_rd_vld} !== 2'b10) begin
            n_bad++;
            $display("FAIL lw_misalign: got mis=%b vld=%b, want 1/0", MEM_misalign, MEM_x_rd_vld);
        end
        flush();
        n_cmp++;
        if (MEM_misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL misalign_pulse: got %b want 0", MEM_misalign);
        end
        send(5'd0, 32'd0, 1'b0, 32'h101, 4'b0000, 1'b0, 4'b0011, 32'h99999999);
        flush();
        n_cmp++;
        if (MEM_misalign !== 1'b1) begin
            n_bad++;
            $display("FAIL sh_misalign: got %b want 1", MEM_misalign);
        end
        send(5'd14, 32'd0, 1'b1, 32'h100, 4'b1111, 1'b0, 4'b0000, 32'd0);
        flush();
        n_cmp++;
        if ({MEM_rd, MEM_x_rd, MEM_x_rd_vld} !== {5'd14, 32'hCAFEF00D, 1'b1}) begin
            n_bad++;
            $display("FAIL sh_suppressed: got rd=%0d x=%h vld=%b, want 14/cafef00d/1", MEM_rd, MEM_x_rd, MEM_x_rd_vld);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_loads();
        test_back_to_back();
        test_pass_through();
        test_store_no_wb();
        test_illegal_pattern();
        test_wrap();
        test_mid_reset();
`ifdef MEM_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RV32 pipeline, the responder for the Execute stage's memory request bus. Holds the core's data RAM. Each cycle it takes one EX-stage result: performs byte-lane stores, performs byte-lane loads with zero or sign extension, or passes ALU/jump results through unchanged. It delivers a single registered write-back triple (rd, value, valid) to the register file two cycles after the request.

## Interface
Parameters:
- ADDR_WIDTH, 12, word-address bits of the data RAM (2^ADDR_WIDTH words, 16 KiB default).

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- EX_rd  in  5  destination register of the EX-stage instruction.
- EX_x_rd  in  32  EX-stage result (ALU/jump link value).
- EX_x_rd_vld  in  1  EX-stage instruction writes rd.
- EX_MEM_addr  in  32  byte address; only bits [ADDR_WIDTH+1:2] index the RAM.
- EX_MEM_rden  in  4  per-byte-lane read enables; non-zero means load.
- EX_MEM_rden_SEXT  in  1  sign-extend load result (lb/lh).
- EX_MEM_wren  in  4  per-byte-lane write enables; non-zero means store.
- EX_MEM_wrdata  in  32  store data, already replicated across lanes.
- MEM_rd  out  5  write-back register index.
- MEM_x_rd  out  32  write-back value.
- MEM_x_rd_vld  out  1  write-back strobe.
- MEM_misalign  out  1  illegal lane pattern flag. Present only with MEM_MISALIGN_CHK_EN.

## Operation
- Stage 1, edge N, inputs sampled:
  - Store: each lane i with wren[i]=1 writes wrdata[8i+7:8i] to RAM[word]. Other lanes keep their value.
  - Load: RAM[word] is read synchronously into rdata_q.
  - rd, x_rd, x_rd_vld, rden, rden_SEXT are latched into s1 registers.
- Stage 2, edge N+1, outputs registered. When s1 rden≠0 the value comes from rdata_q:
  - 0001/0010/0100/1000: byte 0/1/2/3, bits [31:8] are zero or copies of byte bit 7 per SEXT.
  - 0011/1100: low/high half, extended from bit 15 per SEXT.
  - 1111: full word; SEXT is ignored.
  - Any other non-zero pattern: value 0.
- When s1 rden=0, MEM_x_rd = s1 x_rd.
- MEM_x_rd_vld = s1 x_rd_vld AND (rd≠0). A store never writes back, whatever x_rd_vld is.
- If rden and wren are both non-zero in the same cycle, the store executes, the load is dropped, and the write-back for that instruction is forced invalid.
- Address wrap: bits above ADDR_WIDTH+1 and bits [1:0] do not index the RAM, so out-of-range addresses alias modulo RAM size.
- RAM contents are not reset. rst_n clears only the pipeline registers.

## Timing
- Load latency: request at edge N, MEM_x_rd valid after edge N+1. Non-load latency is identical, so write-back order is preserved.
- Store takes effect at edge N. A load presented at N+1 to the same word returns the new data; no bypass logic is required.
- No stall and no back-pressure: one request per cycle, throughput 1.
- Reset values:
  - MEM_rd=0, MEM_x_rd=0, MEM_x_rd_vld=0, MEM_misalign=0.
  - s1 registers cleared, so no write-back occurs.
- Reset asserted mid-operation: in-flight results are discarded and MEM_x_rd_vld is 0 on the first cycle after release. A store sampled at the same edge as reset assertion is not guaranteed to complete.
- Back-to-back loads/stores to the same or different words are legal every cycle.

## Configuration
- MEM_MISALIGN_CHK_EN defined:
  - An access fails if its lane pattern is not one of the seven legal patterns, or does not match EX_MEM_addr[1:0]: word needs 00, half 0011 needs 00 and 1100 needs 10, byte lane k needs k.
  - A failing store is suppressed.
  - A failing load writes back nothing.
  - MEM_misalign pulses high for one cycle, aligned with that instruction's stage-2 output.
- Not defined: the MEM_misalign port and all checking are absent. Lane enables are trusted and applied as given; word selection still uses addr bits only.

## Test plan
- SW 0xDEADBEEF at 0x100, then LB 0x101 with SEXT -> MEM_x_rd=0xFFFFFFBE, vld=1, two cycles after the LB request.
- Same word: LBU 0x103 -> 0x000000DE. LH 0x102 with SEXT -> 0xFFFFDEAD. LHU 0x100 -> 0x0000BEEF.
- SB 0x55 to 0x102 (wren=0100, wrdata=0x55555555), next cycle LW 0x100 -> 0xDE55BEEF, proving the store is visible back-to-back.
- ALU pass-through: rd=5, x_rd=0x12345678, vld=1, rden=wren=0 -> MEM_rd=5, MEM_x_rd=0x12345678 at latency 2. Same with rd=0 -> vld=0.
- Pulse rst_n low for one cycle while a load and an ALU op are in flight -> all outputs 0 during and immediately after reset. An earlier-written word still reads back its value.
- With MEM_MISALIGN_CHK_EN: LW with addr 0x102 -> MEM_misalign=1 and vld=0. SH with wren=0011 at 0x101 -> RAM word unchanged, MEM_misalign=1.
